// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush
// bubbles and a halt FSM that drains the pipeline after opcode 0 decodes.
module id_ex_stage #(
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic              id_alu_src,
  input  logic              id_jal_to_reg,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic [1:0]        id_alu_op,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              ex_flush,
  output logic              ex_alu_src,
  output logic              ex_jal_to_reg,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic              stall,
  output logic              halted
);

  localparam int PW = 7 + 2 + 3 + 7 + 15 + 4 * DATA_W;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          halted_q, halted_d;
  logic [PW-1:0] bundle_q, bundle_d;
  logic [PW-1:0] id_bundle;

  logic in_run;
  logic halt_dec;
  logic hazard;

  assign id_bundle = {id_alu_src, id_jal_to_reg, id_mem_to_reg, id_reg_write,
                      id_mem_read, id_mem_write, id_branch, id_alu_op,
                      id_funct3, id_funct7, id_rs1, id_rs2, id_rd,
                      id_rd1, id_rd2, id_imm, id_pc};

  assign {ex_alu_src, ex_jal_to_reg, ex_mem_to_reg, ex_reg_write,
          ex_mem_read, ex_mem_write, ex_branch, ex_alu_op,
          ex_funct3, ex_funct7, ex_rs1, ex_rs2, ex_rd,
          ex_rd1, ex_rd2, ex_imm, ex_pc} = bundle_q;

  assign in_run   = (state_q == RUN);
  assign halt_dec = in_run && id_valid && (id_opcode == 7'b0000000);

  // rs2 only matters when it is actually read: R-type/branch operand or store data.
  assign hazard = in_run && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                  ((ex_rd == id_rs1) ||
                   ((ex_rd == id_rs2) && (!id_alu_src || id_mem_write)));

  assign stall  = !ex_flush &&
                  (hazard || halt_dec || (state_q == DRAIN) || (state_q == HALTED));
  assign halted = halted_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    bundle_d = '0;
    if (ex_flush) begin
      // A halt seen in decode was on the wrong path; abandon the drain.
      if (state_q == DRAIN) begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    end else begin
      case (state_q)
        HALTED: ;
        DRAIN: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end
        end
        RUN: begin
          if (halt_dec) begin
            if (DRAIN_CYCLES == 1) begin
              state_d  = HALTED;
              halted_d = 1'b1;
              cnt_d    = 4'd0;
            end else begin
              state_d = DRAIN;
              cnt_d   = DRAIN_INIT;
            end
          end else if (!hazard && id_valid) begin
            bundle_d = id_bundle;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      cnt_q    <= 4'd0;
      halted_q <= 1'b0;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      bundle_q <= bundle_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued when a
// decode-stage instruction is driven and compared one edge later.
module tb_id_ex_stage;

  typedef struct packed {
    logic        alu_src;
    logic        jal_to_reg;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } fields_t;

  typedef struct {
    fields_t    f;
    logic [6:0] op;
    logic       v;
    logic       fl;
    logic       ld;
    logic       st;
    logic       hl;
  } step_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_HALT = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = 7'd0;
  logic       ex_flush = 1'b0;
  fields_t    idf = '0;
  fields_t    exf;

  logic        ex_alu_src, ex_jal_to_reg, ex_mem_to_reg, ex_reg_write;
  logic        ex_mem_read, ex_mem_write, ex_branch;
  logic [1:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic        stall, halted;

  fields_t exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_alu_src(idf.alu_src), .id_jal_to_reg(idf.jal_to_reg),
    .id_mem_to_reg(idf.mem_to_reg), .id_reg_write(idf.reg_write),
    .id_mem_read(idf.mem_read), .id_mem_write(idf.mem_write),
    .id_branch(idf.branch), .id_alu_op(idf.alu_op), .id_funct3(idf.funct3),
    .id_funct7(idf.funct7), .id_rs1(idf.rs1), .id_rs2(idf.rs2), .id_rd(idf.rd),
    .id_rd1(idf.rd1), .id_rd2(idf.rd2), .id_imm(idf.imm), .id_pc(idf.pc),
    .ex_flush(ex_flush),
    .ex_alu_src(ex_alu_src), .ex_jal_to_reg(ex_jal_to_reg),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .stall(stall), .halted(halted)
  );

  assign exf = {ex_alu_src, ex_jal_to_reg, ex_mem_to_reg, ex_reg_write,
                ex_mem_read, ex_mem_write, ex_branch, ex_alu_op, ex_funct3,
                ex_funct7, ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc};

  function automatic fields_t mk_r(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                   logic [31:0] a, logic [31:0] b, logic [31:0] pc);
    fields_t f = '0;
    f.reg_write = 1'b1; f.alu_op = 2'b10;
    f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.rd1 = a; f.rd2 = b; f.pc = pc;
    return f;
  endfunction

  function automatic fields_t mk_lw(logic [4:0] rd, logic [4:0] rs1,
                                    logic [31:0] imm, logic [31:0] pc);
    fields_t f = '0;
    f.alu_src = 1'b1; f.mem_to_reg = 1'b1; f.reg_write = 1'b1; f.mem_read = 1'b1;
    f.funct3 = 3'b010; f.rd = rd; f.rs1 = rs1; f.imm = imm; f.pc = pc;
    f.rd1 = 32'h0000_1000;
    return f;
  endfunction

  function automatic fields_t mk_sw(logic [4:0] rs1, logic [4:0] rs2,
                                    logic [31:0] imm, logic [31:0] pc);
    fields_t f = '0;
    f.alu_src = 1'b1; f.mem_write = 1'b1; f.funct3 = 3'b010;
    f.rs1 = rs1; f.rs2 = rs2; f.imm = imm; f.pc = pc; f.rd2 = 32'hCAFE_0001;
    return f;
  endfunction

  function automatic fields_t mk_i(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2f,
                                   logic [31:0] imm, logic [31:0] pc);
    fields_t f = '0;
    f.alu_src = 1'b1; f.reg_write = 1'b1; f.alu_op = 2'b10;
    f.rd = rd; f.rs1 = rs1; f.rs2 = rs2f; f.imm = imm; f.pc = pc;
    return f;
  endfunction

  function automatic step_t mk_step(fields_t f, logic [6:0] op, logic v, logic fl,
                                    logic ld, logic st, logic hl);
    step_t s;
    s.f = f; s.op = op; s.v = v; s.fl = fl; s.ld = ld; s.st = st; s.hl = hl;
    return s;
  endfunction

  task automatic drive(input step_t s);
    idf       = s.f;
    id_opcode = s.op;
    id_valid  = s.v;
    ex_flush  = s.fl;
    exp_q.push_back(s.ld ? s.f : fields_t'('0));
  endtask

  task automatic test_reset();
    idf = mk_r(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'h100);
    id_opcode = OP_R;
    id_valid  = 1'b1;
    reset     = 1'b0;
    #1;
    total++; if (exf !== '0) begin bad++; $display("FAIL reset_ex got=%h want=0", exf); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    @(posedge clk); #1;
    total++; if (exf !== '0) begin bad++; $display("FAIL reset_hold_ex got=%h want=0", exf); end
    reset = 1'b1;
  endtask

  task automatic test_alu();
    step_t   s[$];
    fields_t e;
    s.push_back(mk_step(mk_r(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'h100), OP_R, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_r(5'd9, 5'd4, 5'd8, 32'd1, 32'd2, 32'h104), OP_HALT, 0, 0, 0, 0, 0));
    s.push_back(mk_step(mk_r(5'd4, 5'd3, 5'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'h108), OP_R, 1, 0, 1, 0, 0));
    foreach (s[i]) begin
      drive(s[i]); #1;
      total++; if (stall !== s[i].st) begin bad++; $display("FAIL alu_stall[%0d] got=%b want=%b", i, stall, s[i].st); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++; if (exf !== e) begin bad++; $display("FAIL alu_ex[%0d] got=%h want=%h", i, exf, e); end
      total++; if (halted !== s[i].hl) begin bad++; $display("FAIL alu_halted[%0d] got=%b want=%b", i, halted, s[i].hl); end
    end
  endtask

  task automatic test_load_use();
    step_t   s[$];
    fields_t e;
    s.push_back(mk_step(mk_lw(5'd5, 5'd1, 32'd0, 32'h200), OP_LW, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_r(5'd6, 5'd5, 5'd2, 32'd11, 32'd22, 32'h204), OP_R, 1, 0, 0, 1, 0));
    s.push_back(mk_step(mk_r(5'd6, 5'd5, 5'd2, 32'd11, 32'd22, 32'h204), OP_R, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_lw(5'd0, 5'd1, 32'd4, 32'h208), OP_LW, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_r(5'd6, 5'd0, 5'd2, 32'd0, 32'd22, 32'h20C), OP_R, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_lw(5'd5, 5'd1, 32'd8, 32'h210), OP_LW, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_sw(5'd1, 5'd5, 32'd12, 32'h214), OP_SW, 1, 0, 0, 1, 0));
    s.push_back(mk_step(mk_sw(5'd1, 5'd5, 32'd12, 32'h214), OP_SW, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_lw(5'd5, 5'd1, 32'd16, 32'h218), OP_LW, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_i(5'd7, 5'd1, 5'd5, 32'd5, 32'h21C), OP_I, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_lw(5'd5, 5'd1, 32'd20, 32'h220), OP_LW, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_r(5'd8, 5'd2, 5'd5, 32'd3, 32'd4, 32'h224), OP_R, 1, 0, 0, 1, 0));
    s.push_back(mk_step(mk_r(5'd8, 5'd2, 5'd5, 32'd3, 32'd4, 32'h224), OP_R, 1, 0, 1, 0, 0));
    foreach (s[i]) begin
      drive(s[i]); #1;
      total++; if (stall !== s[i].st) begin bad++; $display("FAIL lu_stall[%0d] got=%b want=%b", i, stall, s[i].st); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++; if (exf !== e) begin bad++; $display("FAIL lu_ex[%0d] got=%h want=%h", i, exf, e); end
      total++; if (halted !== s[i].hl) begin bad++; $display("FAIL lu_halted[%0d] got=%b want=%b", i, halted, s[i].hl); end
    end
  endtask

  task automatic test_flush();
    step_t   s[$];
    fields_t e;
    s.push_back(mk_step(mk_lw(5'd5, 5'd1, 32'd0, 32'h300), OP_LW, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_r(5'd6, 5'd5, 5'd2, 32'd1, 32'd2, 32'h304), OP_R, 1, 1, 0, 0, 0));
    s.push_back(mk_step(mk_r(5'd6, 5'd5, 5'd2, 32'd1, 32'd2, 32'h340), OP_R, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_r(5'd7, 5'd3, 5'd4, 32'd9, 32'd8, 32'h344), OP_R, 1, 1, 0, 0, 0));
    s.push_back(mk_step(mk_r(5'd7, 5'd3, 5'd4, 32'd9, 32'd8, 32'h380), OP_R, 1, 0, 1, 0, 0));
    foreach (s[i]) begin
      drive(s[i]); #1;
      total++; if (stall !== s[i].st) begin bad++; $display("FAIL flush_stall[%0d] got=%b want=%b", i, stall, s[i].st); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++; if (exf !== e) begin bad++; $display("FAIL flush_ex[%0d] got=%h want=%h", i, exf, e); end
      total++; if (halted !== s[i].hl) begin bad++; $display("FAIL flush_halted[%0d] got=%b want=%b", i, halted, s[i].hl); end
    end
  endtask

  task automatic test_back_to_back();
    step_t        s[$];
    fields_t      e;
    fields_t      f;
    logic [191:0] raw;
    for (int k = 0; k < 6; k++) begin
      raw = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      f = fields_t'(raw[161:0]);
      f.mem_read = 1'b0;
      s.push_back(mk_step(f, OP_R, 1, 0, 1, 0, 0));
    end
    foreach (s[i]) begin
      drive(s[i]); #1;
      total++; if (stall !== s[i].st) begin bad++; $display("FAIL b2b_stall[%0d] got=%b want=%b", i, stall, s[i].st); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++; if (exf !== e) begin bad++; $display("FAIL b2b_ex[%0d] got=%h want=%h", i, exf, e); end
      total++; if (halted !== s[i].hl) begin bad++; $display("FAIL b2b_halted[%0d] got=%b want=%b", i, halted, s[i].hl); end
    end
  endtask

  task automatic test_halt();
    step_t   s[$];
    fields_t e;
    fields_t a;
    a = mk_r(5'd10, 5'd11, 5'd12, 32'd100, 32'd200, 32'h400);
    s.push_back(mk_step('0, OP_HALT, 1, 0, 0, 1, 0));
    s.push_back(mk_step(a, OP_R, 1, 0, 0, 1, 0));
    s.push_back(mk_step(a, OP_R, 1, 0, 0, 1, 1));
    s.push_back(mk_step(a, OP_R, 1, 0, 0, 1, 1));
    s.push_back(mk_step(a, OP_R, 1, 1, 0, 0, 1));
    s.push_back(mk_step(a, OP_R, 1, 0, 0, 1, 1));
    foreach (s[i]) begin
      drive(s[i]); #1;
      total++; if (stall !== s[i].st) begin bad++; $display("FAIL halt_stall[%0d] got=%b want=%b", i, stall, s[i].st); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++; if (exf !== e) begin bad++; $display("FAIL halt_ex[%0d] got=%h want=%h", i, exf, e); end
      total++; if (halted !== s[i].hl) begin bad++; $display("FAIL halt_halted[%0d] got=%b want=%b", i, halted, s[i].hl); end
    end
    ex_flush = 1'b0;
    reset = 1'b0;
    #1;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset_halted got=%b want=0", halted); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL halt_reset_stall got=%b want=0", stall); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_halt_flush();
    step_t   s[$];
    fields_t e;
    s.push_back(mk_step('0, OP_HALT, 1, 0, 0, 1, 0));
    s.push_back(mk_step(mk_r(5'd13, 5'd1, 5'd2, 32'd3, 32'd4, 32'h500), OP_R, 1, 1, 0, 0, 0));
    s.push_back(mk_step(mk_r(5'd14, 5'd1, 5'd2, 32'd5, 32'd6, 32'h540), OP_R, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_r(5'd15, 5'd3, 5'd4, 32'd7, 32'd8, 32'h544), OP_R, 1, 0, 1, 0, 0));
    s.push_back(mk_step(mk_r(5'd16, 5'd3, 5'd4, 32'd9, 32'd1, 32'h548), OP_R, 1, 0, 1, 0, 0));
    s.push_back(mk_step('0, OP_HALT, 1, 0, 0, 1, 0));
    foreach (s[i]) begin
      drive(s[i]); #1;
      total++; if (stall !== s[i].st) begin bad++; $display("FAIL hflush_stall[%0d] got=%b want=%b", i, stall, s[i].st); end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++; if (exf !== e) begin bad++; $display("FAIL hflush_ex[%0d] got=%h want=%h", i, exf, e); end
      total++; if (halted !== s[i].hl) begin bad++; $display("FAIL hflush_halted[%0d] got=%b want=%b", i, halted, s[i].hl); end
    end
    idf = mk_r(5'd17, 5'd5, 5'd6, 32'd1, 32'd2, 32'h550);
    id_opcode = OP_R;
    id_valid  = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL drain_stall got=%b want=1", stall); end
    reset = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL drain_reset_stall got=%b want=0", stall); end
    total++; if (exf !== '0) begin bad++; $display("FAIL drain_reset_ex got=%h want=0", exf); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL drain_reset_halted got=%b want=0", halted); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (exf !== idf) begin bad++; $display("FAIL post_reset_ex got=%h want=%h", exf, idf); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_halt();
    test_halt_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
